keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_pkg.sv | 26 ++
 rtl/keypad_row_sync.sv | 23 ++
 rtl/keypad_scanner.sv | 128 ++++++++++++
 tb/tb_keypad_scanner.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and constants for the keypad scanner
package keypad_pkg;

    localparam int KEY_W = 4;
    localparam logic [3:0] ROWS_IDLE = 4'hF;
    localparam logic [3:0] COL_RESET = 4'b1110;

    typedef enum logic [2:0] {
        SCAN,
        DEB,
        EMIT,
        HOLD,
        REL
    } state_t;

    // Lowest-index active-low row; callers only use it when some row is low.
    function automatic logic [1:0] lowest_low(input logic [3:0] rows);
        logic [1:0] r;
        r = 2'd3;
        for (int i = 3; i >= 0; i--) begin
            if (!rows[i]) r = 2'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// rtl/keypad_row_sync.sv - 2-flop synchronizer for the asynchronous row lines
module keypad_row_sync
    import keypad_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            meta <= ROWS_IDLE;
            q    <= ROWS_IDLE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad scanner with debounce; KEYPAD_REPEAT_EN adds auto-repeat
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_TICKS     = 50000,
    parameter int DEBOUNCE_TICKS = 1000000,
    parameter int REPEAT_TICKS   = 25000000
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [3:0]       ROWS,
    output logic [3:0]       COLS,
    output logic [KEY_W-1:0] KEY,
    output logic             KEYVALID
);

    localparam logic [19:0] SCAN_LAST = 20'(SCAN_TICKS - 1);
    // DEB and REL run DEBOUNCE_TICKS+1 edges so the pulse lands DEBOUNCE_TICKS+1 after entry.
    localparam logic [19:0] DEB_LAST  = 20'(DEBOUNCE_TICKS);

    if (DEBOUNCE_TICKS >= (1 << 20) || SCAN_TICKS < 1 || REPEAT_TICKS < 2) begin : g_bad_params
        $error("keypad_scanner: parameter out of range");
    end

    state_t      state;
    logic [1:0]  col;
    logic [1:0]  row;
    logic [19:0] cnt;
    logic [3:0]  rs;

`ifdef KEYPAD_REPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_TICKS);
    // HOLD is entered one edge after EMIT, hence the -2 to repeat every REPEAT_TICKS.
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_TICKS - 2);
    logic [RPT_W-1:0] rcnt;
`endif

    keypad_row_sync u_sync (
        .CLK   (CLK),
        .RESET (RESET),
        .d     (ROWS),
        .q     (rs)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= SCAN;
            col      <= 2'd0;
            row      <= 2'd0;
            cnt      <= '0;
            COLS     <= COL_RESET;
            KEY      <= '0;
            KEYVALID <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rcnt     <= '0;
`endif
        end else begin
            KEYVALID <= 1'b0;
            case (state)
                SCAN: begin
                    if (cnt == SCAN_LAST) begin
                        cnt <= '0;
                        if (rs == ROWS_IDLE) begin
                            col  <= col + 2'd1;
                            COLS <= {COLS[2:0], COLS[3]};
                        end else begin
                            row   <= lowest_low(rs);
                            state <= DEB;
                        end
                    end else begin
                        cnt <= cnt + 20'd1;
                    end
                end
                DEB: begin
                    if (rs[row]) begin
                        cnt   <= '0;
                        state <= SCAN;
                    end else if (cnt == DEB_LAST) begin
                        cnt      <= '0;
                        KEY      <= {row, col};
                        KEYVALID <= 1'b1;
                        state    <= EMIT;
                    end else begin
                        cnt <= cnt + 20'd1;
                    end
                end
                EMIT: begin
                    state <= HOLD;
`ifdef KEYPAD_REPEAT_EN
                    rcnt  <= '0;
`endif
                end
                HOLD: begin
                    if (rs[row]) begin
                        cnt   <= '0;
                        state <= REL;
                    end
`ifdef KEYPAD_REPEAT_EN
                    else if (rcnt == RPT_LAST) begin
                        rcnt     <= '0;
                        KEYVALID <= 1'b1;
                        state    <= EMIT;
                    end else begin
                        rcnt <= rcnt + 1'b1;
                    end
`endif
                end
                REL: begin
                    if (!rs[row]) begin
                        state <= HOLD;
`ifdef KEYPAD_REPEAT_EN
                        rcnt  <= '0;
`endif
                    end else if (cnt == DEB_LAST) begin
                        cnt   <= '0;
                        col   <= col + 2'd1;
                        COLS  <= {COLS[2:0], COLS[3]};
                        state <= SCAN;
                    end else begin
                        cnt <= cnt + 20'd1;
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - scoreboard bench for keypad_scanner (SCAN=4, DEBOUNCE=8, REPEAT=20)
module tb_keypad_scanner;

    logic       CLK;
    logic       RESET;
    logic [3:0] ROWS;
    logic [3:0] COLS;
    logic [3:0] KEY;
    logic       KEYVALID;

    typedef struct {
        logic [3:0] key;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   pulses = 0;
    int   errors = 0;
    int   checks = 0;

    keypad_scanner #(
        .SCAN_TICKS     (4),
        .DEBOUNCE_TICKS (8),
        .REPEAT_TICKS   (20)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .ROWS     (ROWS),
        .COLS     (COLS),
        .KEY      (KEY),
        .KEYVALID (KEYVALID)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Expected key: lowest low row * 4 + column.
    function automatic logic [3:0] key_of(input logic [3:0] rows, input int c);
        int r;
        r = 0;
        for (int i = 3; i >= 0; i--) if (!rows[i]) r = i;
        return 4'(r * 4 + c);
    endfunction

    always @(negedge CLK) begin
        if (KEYVALID === 1'b1) begin
            exp_t e;
            pulses++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse key=%0d cyc=%0d", KEY, cyc);
            end else begin
                e = exp_q.pop_front();
                if (KEY !== e.key || cyc !== e.cyc) begin
                    errors++;
                    $display("FAIL pulse key=%0d cyc=%0d expected key=%0d cyc=%0d", KEY, cyc, e.key, e.cyc);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_col(input logic [3:0] val, output int t);
        int n;
        n = 0;
        while (COLS === val && n < 100) begin @(negedge CLK); n++; end
        while (COLS !== val && n < 100) begin @(negedge CLK); n++; end
        t = cyc;
        if (n >= 100) begin
            errors++;
            checks++;
            $display("FAIL wait_col timeout cols=%b expected %b", COLS, val);
        end
    endtask

    task automatic check_pulses(input string name, input int p0, input int n);
        #2;
        checks++;
        if (pulses - p0 !== n) begin
            errors++;
            $display("FAIL %s pulses=%0d expected %0d", name, pulses - p0, n);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s missing_pulses=%0d expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        ROWS  = 4'hF;
        idle(3);
        checks += 3;
        if (COLS !== 4'b1110) begin errors++; $display("FAIL reset_cols cols=%b expected 1110", COLS); end
        if (KEY !== 4'h0) begin errors++; $display("FAIL reset_key key=%0d expected 0", KEY); end
        if (KEYVALID !== 1'b0) begin errors++; $display("FAIL reset_keyvalid kv=%b expected 0", KEYVALID); end
        RESET = 1'b0;
    endtask

    task automatic test_idle();
        logic [3:0] one;
        logic [3:0] exp_cols;
        int p0;
        one = 4'b0001;
        p0  = pulses;
        for (int k = 1; k <= 64; k++) begin
            @(negedge CLK);
            exp_cols = ~(one << ((k / 4) % 4));
            checks++;
            if (COLS !== exp_cols) begin
                errors++;
                $display("FAIL idle_cols k=%0d cols=%b expected %b", k, COLS, exp_cols);
            end
        end
        check_pulses("idle", p0, 0);
    endtask

    task automatic test_clean_press();
        int t, t2, p0;
        p0 = pulses;
        wait_col(4'b1101, t);
        ROWS = 4'b1011;
        exp_q.push_back('{key_of(4'b1011, 1), t + 13});
`ifdef KEYPAD_REPEAT_EN
        exp_q.push_back('{key_of(4'b1011, 1), t + 33});
`endif
        idle(40);
        ROWS = 4'hF;
        wait_col(4'b1011, t2);
        checks++;
        if (t2 !== t + 52) begin
            errors++;
            $display("FAIL press_rescan cyc=%0d expected %0d", t2, t + 52);
        end
`ifdef KEYPAD_REPEAT_EN
        check_pulses("clean_press", p0, 2);
`else
        check_pulses("clean_press", p0, 1);
`endif
    endtask

    task automatic test_bounce();
        int t, p0;
        p0 = pulses;
        wait_col(4'b1110, t);
        ROWS = 4'b1110;
        idle(3);
        ROWS = 4'hF;
        idle(6);
        checks++;
        if (COLS !== 4'b1110) begin errors++; $display("FAIL bounce_hold cols=%b expected 1110", COLS); end
        idle(1);
        checks++;
        if (COLS !== 4'b1101) begin errors++; $display("FAIL bounce_next cols=%b expected 1101", COLS); end
        idle(20);
        check_pulses("bounce", p0, 0);
    endtask

    task automatic test_release_glitch();
        int t, t2, p0;
        p0 = pulses;
        wait_col(4'b1011, t);
        ROWS = 4'b0111;
        exp_q.push_back('{key_of(4'b0111, 2), t + 13});
        idle(20);
        ROWS = 4'hF;
        idle(2);
        ROWS = 4'b0111;
        idle(8);
        checks++;
        if (COLS !== 4'b1011) begin errors++; $display("FAIL glitch_hold cols=%b expected 1011", COLS); end
        ROWS = 4'b0110;
        idle(10);
        ROWS = 4'hF;
        wait_col(4'b0111, t2);
        idle(5);
        check_pulses("release_glitch", p0, 1);
    endtask

    task automatic test_multi_row();
        logic [3:0] pats [2];
        int t, p0;
        pats[0] = 4'b0101;
        pats[1] = 4'b1010;
        p0 = pulses;
        for (int i = 0; i < 2; i++) begin
            wait_col(4'b0111, t);
            ROWS = pats[i];
            exp_q.push_back('{key_of(pats[i], 3), t + 13});
            idle(20);
            ROWS = 4'hF;
            wait_col(4'b1110, t);
        end
        check_pulses("multi_row", p0, 2);
    endtask

    task automatic test_reset_mid_deb();
        int t, p0;
        p0 = pulses;
        wait_col(4'b1101, t);
        ROWS = 4'b1011;
        idle(7);
        RESET = 1'b1;
        ROWS  = 4'hF;
        idle(1);
        checks += 3;
        if (COLS !== 4'b1110) begin errors++; $display("FAIL middeb_cols cols=%b expected 1110", COLS); end
        if (KEY !== 4'h0) begin errors++; $display("FAIL middeb_key key=%0d expected 0", KEY); end
        if (KEYVALID !== 1'b0) begin errors++; $display("FAIL middeb_keyvalid kv=%b expected 0", KEYVALID); end
        RESET = 1'b0;
        idle(40);
        check_pulses("reset_mid_deb", p0, 0);
    endtask

    task automatic test_repeat();
        int t, e, p0;
        p0 = pulses;
        wait_col(4'b1101, t);
        ROWS = 4'b1011;
        e = t + 13;
        exp_q.push_back('{key_of(4'b1011, 1), e});
`ifdef KEYPAD_REPEAT_EN
        exp_q.push_back('{key_of(4'b1011, 1), e + 20});
        exp_q.push_back('{key_of(4'b1011, 1), e + 40});
        exp_q.push_back('{key_of(4'b1011, 1), e + 60});
`endif
        idle(83);
        ROWS = 4'hF;
        idle(30);
`ifdef KEYPAD_REPEAT_EN
        check_pulses("repeat", p0, 4);
`else
        check_pulses("repeat", p0, 1);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_idle();
        test_clean_press();
        test_bounce();
        test_release_glitch();
        test_multi_row();
        test_reset_mid_deb();
        test_repeat();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
